// File: rtl/snn_core_sequencer.sv
// -----------------------------------------------------------------------------
// snn_core_sequencer
//
// Run controller for a single SNN core. It streams per-neuron configuration
// beats from the host into the core's parameter and instruction memories. It
// then issues a programmed number of `tick` timesteps, waiting for the core's
// `tick_ready` after each one. It is the only agent that drives the core's
// config write ports and its `tick` input.
//
// Ports
//   clk                  in   1           single clock, posedge
//   reset_n              in   1           synchronous active-low reset
//   cfg_load             in   1           start a config load (IDLE only)
//   start                in   1           start a run (IDLE only)
//   num_ticks            in   16          timesteps per run, sampled with start
//   host_valid           in   1           config beat valid
//   host_ready           out  1           config beat accepted when valid&ready
//   host_param           in   PARAM_WIDTH parameter word of current neuron
//   host_inst            in   2           instruction code of current neuron
//   param_wen            out  1           parameter-memory write strobe
//   param_address        out  AW          parameter-memory write address
//   param_data_in        out  PARAM_WIDTH parameter-memory write data
//   neuron_inst_wen      out  1           instruction-memory write strobe
//   neuron_inst_address  out  AW          instruction-memory write address
//   neuron_inst_data_in  out  2           instruction-memory write data
//   tick                 out  1           one-cycle timestep pulse
//   tick_ready           in   1           core finished the timestep
//   busy                 out  1           not in IDLE
//   cfg_done             out  1           pulse with the final config write
//   done                 out  1           pulse when a run completes
//   timeout_error        out  1           sticky, a timestep timed out
//   tick_count           out  16          timesteps completed in this/last run
//
// AW = $clog2(NUM_NEURONS). All outputs are registered.
// -----------------------------------------------------------------------------
module snn_core_sequencer #(
    parameter int NUM_NEURONS = 256,
    parameter int PARAM_WIDTH = 368,
    parameter int TIMEOUT     = 4096
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           cfg_load,
    input  logic                           start,
    input  logic [15:0]                    num_ticks,
    input  logic                           host_valid,
    output logic                           host_ready,
    input  logic [PARAM_WIDTH-1:0]         host_param,
    input  logic [1:0]                     host_inst,
    output logic                           param_wen,
    output logic [$clog2(NUM_NEURONS)-1:0] param_address,
    output logic [PARAM_WIDTH-1:0]         param_data_in,
    output logic                           neuron_inst_wen,
    output logic [$clog2(NUM_NEURONS)-1:0] neuron_inst_address,
    output logic [1:0]                     neuron_inst_data_in,
    output logic                           tick,
    input  logic                           tick_ready,
    output logic                           busy,
    output logic                           cfg_done,
    output logic                           done,
    output logic                           timeout_error,
    output logic [15:0]                    tick_count
);

    localparam int ADDR_W = $clog2(NUM_NEURONS);
    localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NEURONS - 1);
    localparam logic [TW-1:0]     TO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TICK,
        S_WAIT,
        S_GAP,
        S_FIN
    } state_e;

    state_e                 state_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [TW-1:0]          timer_q;
    logic [15:0]            num_q;

    logic                   host_ready_q;
    logic                   param_wen_q;
    logic [ADDR_W-1:0]      param_address_q;
    logic [PARAM_WIDTH-1:0] param_data_in_q;
    logic                   neuron_inst_wen_q;
    logic [ADDR_W-1:0]      neuron_inst_address_q;
    logic [1:0]             neuron_inst_data_in_q;
    logic                   tick_q;
    logic                   busy_q;
    logic                   cfg_done_q;
    logic                   done_q;
    logic                   timeout_error_q;
    logic [15:0]            tick_count_q;

    // Next-value helpers shared by several FSM branches.
    logic [ADDR_W-1:0]      addr_d;
    logic [TW-1:0]          timer_d;
    logic [15:0]            tick_count_d;
    logic                   beat_accept;
    logic                   last_beat;

    // NOTE: every signal driven here gets a value on every path through the
    // block; a path that leaves one unassigned would infer a latch.
    always_comb begin
        addr_d       = addr_q + ADDR_W'(1);
        timer_d      = timer_q + TW'(1);
        tick_count_d = tick_count_q + 16'd1;
        beat_accept  = (state_q == S_LOAD) && host_valid && host_ready_q;
        last_beat    = (addr_q == LAST_ADDR);
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every branch below reads the pre-edge value of every register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q               <= S_IDLE;
            addr_q                <= '0;
            timer_q               <= '0;
            num_q                 <= '0;
            host_ready_q          <= 1'b0;
            param_wen_q           <= 1'b0;
            param_address_q       <= '0;
            param_data_in_q       <= '0;
            neuron_inst_wen_q     <= 1'b0;
            neuron_inst_address_q <= '0;
            neuron_inst_data_in_q <= '0;
            tick_q                <= 1'b0;
            busy_q                <= 1'b0;
            cfg_done_q            <= 1'b0;
            done_q                <= 1'b0;
            timeout_error_q       <= 1'b0;
            tick_count_q          <= '0;
        end else begin
            // Single-cycle strobes default low; the branches raise them.
            param_wen_q       <= 1'b0;
            neuron_inst_wen_q <= 1'b0;
            tick_q            <= 1'b0;
            cfg_done_q        <= 1'b0;
            done_q            <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    // cfg_load has priority; a simultaneous start is dropped.
                    if (cfg_load) begin
                        state_q         <= S_LOAD;
                        addr_q          <= '0;
                        timeout_error_q <= 1'b0;
                        host_ready_q    <= 1'b1;
                        busy_q          <= 1'b1;
                    end else if (start) begin
                        num_q           <= num_ticks;
                        tick_count_q    <= '0;
                        timeout_error_q <= 1'b0;
                        busy_q          <= 1'b1;
                        if (num_ticks == 16'd0) begin
                            state_q <= S_FIN;
                        end else begin
                            state_q <= S_TICK;
                            tick_q  <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    if (beat_accept) begin
                        param_wen_q           <= 1'b1;
                        neuron_inst_wen_q     <= 1'b1;
                        param_address_q       <= addr_q;
                        neuron_inst_address_q <= addr_q;
                        param_data_in_q       <= host_param;
                        neuron_inst_data_in_q <= host_inst;
                        if (last_beat) begin
                            // cfg_done lines up with the final write strobe.
                            state_q      <= S_IDLE;
                            host_ready_q <= 1'b0;
                            busy_q       <= 1'b0;
                            cfg_done_q   <= 1'b1;
                        end else begin
                            addr_q <= addr_d;
                        end
                    end
                end

                S_TICK: begin
                    // tick_ready during the tick cycle itself is not a response.
                    state_q <= S_WAIT;
                    timer_q <= '0;
                end

                S_WAIT: begin
                    // A response in the last allowed cycle still counts.
                    if (tick_ready) begin
                        tick_count_q <= tick_count_d;
                        if (tick_count_d == num_q) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_GAP;
                        end
                    end else if (timer_q == TO_LAST) begin
                        state_q         <= S_IDLE;
                        timeout_error_q <= 1'b1;
                        busy_q          <= 1'b0;
                    end else begin
                        timer_q <= timer_d;
                    end
                end

                S_GAP: begin
                    state_q <= S_TICK;
                    tick_q  <= 1'b1;
                end

                S_FIN: begin
                    // Entered from WAIT with done already raised, or from IDLE
                    // (zero-tick run) with done low: raise it once, then leave.
                    if (done_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        done_q <= 1'b1;
                    end
                end

                default: begin
                    state_q      <= S_IDLE;
                    host_ready_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign host_ready          = host_ready_q;
    assign param_wen           = param_wen_q;
    assign param_address       = param_address_q;
    assign param_data_in       = param_data_in_q;
    assign neuron_inst_wen     = neuron_inst_wen_q;
    assign neuron_inst_address = neuron_inst_address_q;
    assign neuron_inst_data_in = neuron_inst_data_in_q;
    assign tick                = tick_q;
    assign busy                = busy_q;
    assign cfg_done            = cfg_done_q;
    assign done                = done_q;
    assign timeout_error       = timeout_error_q;
    assign tick_count          = tick_count_q;

endmodule

// File: tb/tb_snn_core_sequencer.sv
// -----------------------------------------------------------------------------
// tb_snn_core_sequencer
//
// Self-checking bench for snn_core_sequencer. Each scenario task drives its
// own stimulus and compares outputs against expectations computed from the
// sequencer's documented timing: the tick schedule is t0 = start+1 with period
// lat+2, done follows the last response by one cycle, and loads produce one
// write per accepted beat, one cycle later.
// -----------------------------------------------------------------------------
module tb_snn_core_sequencer;

    localparam int NN = 256;
    localparam int PW = 368;
    localparam int TO = 16;
    localparam int AW = $clog2(NN);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cfg_load;
    logic          start;
    logic [15:0]   num_ticks;
    logic          host_valid;
    logic          host_ready;
    logic [PW-1:0] host_param;
    logic [1:0]    host_inst;
    logic          param_wen;
    logic [AW-1:0] param_address;
    logic [PW-1:0] param_data_in;
    logic          neuron_inst_wen;
    logic [AW-1:0] neuron_inst_address;
    logic [1:0]    neuron_inst_data_in;
    logic          tick;
    logic          tick_ready;
    logic          busy;
    logic          cfg_done;
    logic          done;
    logic          timeout_error;
    logic [15:0]   tick_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    snn_core_sequencer #(
        .NUM_NEURONS (NN),
        .PARAM_WIDTH (PW),
        .TIMEOUT     (TO)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .cfg_load            (cfg_load),
        .start               (start),
        .num_ticks           (num_ticks),
        .host_valid          (host_valid),
        .host_ready          (host_ready),
        .host_param          (host_param),
        .host_inst           (host_inst),
        .param_wen           (param_wen),
        .param_address       (param_address),
        .param_data_in       (param_data_in),
        .neuron_inst_wen     (neuron_inst_wen),
        .neuron_inst_address (neuron_inst_address),
        .neuron_inst_data_in (neuron_inst_data_in),
        .tick                (tick),
        .tick_ready          (tick_ready),
        .busy                (busy),
        .cfg_done            (cfg_done),
        .done                (done),
        .timeout_error       (timeout_error),
        .tick_count          (tick_count)
    );

    // Advance one cycle and settle just after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare every output against zero.
    task automatic check_all_zero(input string tag);
        logic [7:0] flags;
        flags = {host_ready, param_wen, neuron_inst_wen, tick, busy, cfg_done, done, timeout_error};
        n_tests++;
        if (flags !== 8'b0) begin
            n_fail++;
            $display("FAIL %s_flags: got %b expected 00000000", tag, flags);
        end
        n_tests++;
        if (param_address !== '0 || neuron_inst_address !== '0) begin
            n_fail++;
            $display("FAIL %s_addr: got %0d/%0d expected 0/0", tag, param_address, neuron_inst_address);
        end
        n_tests++;
        if (param_data_in !== '0 || neuron_inst_data_in !== '0) begin
            n_fail++;
            $display("FAIL %s_data: got %h/%0d expected 0/0", tag, param_data_in, neuron_inst_data_in);
        end
        n_tests++;
        if (tick_count !== 16'd0) begin
            n_fail++;
            $display("FAIL %s_tick_count: got %0d expected 0", tag, tick_count);
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        cfg_load   = 1'b0;
        start      = 1'b0;
        num_ticks  = '0;
        host_valid = 1'b0;
        host_param = '0;
        host_inst  = '0;
        tick_ready = 1'b0;
        step();
        step();
        check_all_zero("reset");
        reset_n = 1'b1;
        step();
        check_all_zero("post_reset");
    endtask

    // Load NN beats with randomly stalled host_valid. Beat k carries its index
    // replicated across the parameter word and k%4 as the instruction.
    task automatic test_load_stalls();
        logic [PW-1:0] exp_param;
        int            beat;
        int            pend;
        int            writes;
        bit            have_pend;
        bit            v;
        cfg_load   = 1'b1;
        host_valid = 1'b0;
        step();
        cfg_load  = 1'b0;
        beat      = 0;
        pend      = 0;
        writes    = 0;
        have_pend = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (have_pend) begin
                exp_param = {46{8'(pend)}};
                writes++;
                n_tests++;
                if (param_wen !== 1'b1 || neuron_inst_wen !== 1'b1) begin
                    n_fail++;
                    $display("FAIL load_wen beat %0d: got %b%b expected 11", pend, param_wen, neuron_inst_wen);
                end
                n_tests++;
                if (param_address !== AW'(pend) || neuron_inst_address !== AW'(pend)) begin
                    n_fail++;
                    $display("FAIL load_addr: got %0d/%0d expected %0d", param_address, neuron_inst_address, pend);
                end
                n_tests++;
                if (param_data_in !== exp_param) begin
                    n_fail++;
                    $display("FAIL load_param beat %0d: got %h expected %h", pend, param_data_in, exp_param);
                end
                n_tests++;
                if (neuron_inst_data_in !== 2'(pend % 4)) begin
                    n_fail++;
                    $display("FAIL load_inst beat %0d: got %0d expected %0d", pend, neuron_inst_data_in, pend % 4);
                end
                n_tests++;
                if (cfg_done !== (pend == NN - 1)) begin
                    n_fail++;
                    $display("FAIL load_cfg_done beat %0d: got %b expected %b", pend, cfg_done, pend == NN - 1);
                end
            end else begin
                n_tests++;
                if ({param_wen, neuron_inst_wen, cfg_done} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL load_idle_strobe: got %b expected 000", {param_wen, neuron_inst_wen, cfg_done});
                end
            end
            have_pend = 1'b0;
            if (beat == NN) break;
            n_tests++;
            if (host_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL load_ready beat %0d: got %b expected 1", beat, host_ready);
            end
            v          = 1'($urandom_range(0, 1));
            host_valid = v;
            host_param = {46{8'(beat)}};
            host_inst  = 2'(beat % 4);
            if (v) begin
                pend      = beat;
                have_pend = 1'b1;
                beat++;
            end
            step();
        end
        host_valid = 1'b0;
        n_tests++;
        if (writes != NN) begin
            n_fail++;
            $display("FAIL load_write_count: got %0d expected %0d", writes, NN);
        end
        n_tests++;
        if (host_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL load_after: got ready=%b busy=%b expected 0 0", host_ready, busy);
        end
        step();
        n_tests++;
        if ({param_wen, neuron_inst_wen, cfg_done, host_ready} !== 4'b0) begin
            n_fail++;
            $display("FAIL load_tail: got %b expected 0000", {param_wen, neuron_inst_wen, cfg_done, host_ready});
        end
    endtask

    // Run n timesteps with the core answering lat cycles after each tick.
    // Optionally pulse tick_ready in the first tick cycle, which must be ignored.
    task automatic test_run(input int n, input int lat, input bit spurious);
        int  period;
        int  done_at;
        int  exp_count;
        bit  exp_tick;
        bit  rdy;
        period  = lat + 2;
        done_at = (n == 0) ? 2 : 1 + (n - 1) * period + lat + 1;
        for (int i = 0; i <= done_at + 2; i++) begin
            if (i > 0) begin
                exp_tick  = (n > 0) && ((i - 1) % period == 0) && ((i - 1) / period < n);
                exp_count = 0;
                for (int k = 0; k < n; k++)
                    if (1 + k * period + lat < i) exp_count++;
                n_tests++;
                if ({tick, done, busy} !== {exp_tick, i == done_at, i <= done_at}) begin
                    n_fail++;
                    $display("FAIL run%0d_lat%0d_ctrl cyc %0d: got tick/done/busy=%b%b%b expected %b%b%b",
                             n, lat, i, tick, done, busy, exp_tick, i == done_at, i <= done_at);
                end
                n_tests++;
                if (tick_count !== 16'(exp_count)) begin
                    n_fail++;
                    $display("FAIL run%0d_lat%0d_count cyc %0d: got %0d expected %0d", n, lat, i, tick_count, exp_count);
                end
                n_tests++;
                if (timeout_error !== 1'b0) begin
                    n_fail++;
                    $display("FAIL run%0d_lat%0d_timeout cyc %0d: got %b expected 0", n, lat, i, timeout_error);
                end
            end
            rdy = spurious && (i == 1);
            for (int k = 0; k < n; k++)
                if (i == 1 + k * period + lat) rdy = 1'b1;
            start      = (i == 0);
            num_ticks  = 16'(n);
            tick_ready = rdy;
            step();
        end
        start      = 1'b0;
        tick_ready = 1'b0;
    endtask

    // No response to the first tick: the run aborts with timeout_error.
    task automatic test_timeout();
        for (int i = 0; i <= TO + 4; i++) begin
            if (i > 0) begin
                n_tests++;
                if ({tick, done, busy, timeout_error} !== {i == 1, 1'b0, i <= TO + 1, i >= TO + 2}) begin
                    n_fail++;
                    $display("FAIL timeout cyc %0d: got tick/done/busy/err=%b%b%b%b expected %b0%b%b",
                             i, tick, done, busy, timeout_error, i == 1, i <= TO + 1, i >= TO + 2);
                end
                n_tests++;
                if (tick_count !== 16'd0) begin
                    n_fail++;
                    $display("FAIL timeout_count cyc %0d: got %0d expected 0", i, tick_count);
                end
            end
            start      = (i == 0);
            num_ticks  = 16'd2;
            tick_ready = 1'b0;
            step();
        end
        start = 1'b0;
    endtask

    // cfg_load and start together enter LOAD only; a start during LOAD is
    // also ignored. host_valid is held high, so the load takes NN+1 cycles.
    task automatic test_commands();
        logic [4:0] exp;
        cfg_load   = 1'b1;
        start      = 1'b1;
        num_ticks  = 16'd5;
        host_valid = 1'b0;
        step();
        cfg_load = 1'b0;
        for (int i = 1; i <= NN + 6; i++) begin
            exp = {1'b0, 1'b0, i <= NN, i == NN + 1, i <= NN};
            n_tests++;
            if ({tick, done, host_ready, cfg_done, busy} !== exp) begin
                n_fail++;
                $display("FAIL commands cyc %0d: got tick/done/ready/cfg_done/busy=%b expected %b",
                         i, {tick, done, host_ready, cfg_done, busy}, exp);
            end
            start      = (i == 1) || (i == 100);
            host_valid = 1'b1;
            host_param = {46{8'(i)}};
            host_inst  = 2'(i % 4);
            step();
        end
        start      = 1'b0;
        host_valid = 1'b0;
    endtask

    // Reset in WAIT after one timestep completed; outputs clear and the
    // sequencer stays idle until the next start.
    task automatic test_reset_mid_run();
        for (int i = 0; i <= 6; i++) begin
            if (i == 6) begin
                n_tests++;
                if (busy !== 1'b1 || tick_count !== 16'd1) begin
                    n_fail++;
                    $display("FAIL midrun_pre: got busy=%b count=%0d expected 1 1", busy, tick_count);
                end
            end
            start      = (i == 0);
            num_ticks  = 16'd3;
            tick_ready = (i == 3);
            reset_n    = (i != 6);
            step();
        end
        check_all_zero("midrun_reset");
        reset_n = 1'b1;
        step();
        n_tests++;
        if ({tick, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrun_idle: got tick/busy/done=%b expected 000", {tick, busy, done});
        end
    endtask

    initial begin
        int n;
        int lat;
        test_reset();
        test_load_stalls();
        test_run(3, 5, 1'b0);
        test_run(0, 1, 1'b0);
        test_timeout();
        test_run(1, 3, 1'b0);
        test_commands();
        test_run(2, 4, 1'b1);
        test_reset_mid_run();
        test_run(1, 2, 1'b0);
        for (int r = 0; r < 6; r++) begin
            n   = $urandom_range(1, 4);
            lat = $urandom_range(2, TO - 2);
            test_run(n, lat, 1'($urandom_range(0, 1)));
        end
        test_run(2, TO, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
